ahb_rr_arbiter: RTL and testbench
=================================

# ahb_rr_arbiter

Round-robin AHB bus arbiter placed in front of `ahb_to_apb_bridge`. It lets `N_MASTERS` AHB-Lite-style masters share the single bridge slave port. It grants bus ownership with AHB2-style `HGRANT`/`HMASTER` handover and multiplexes address, control and write data onto the bridge inputs. A per-owner transfer cap prevents starvation when several masters compete.

## Interface
- `N_MASTERS`, 2: number of requesting masters (2..8).
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `MAX_HOLD`, 4: accepted transfers an owner may complete before forced re-arbitration while others request (1..15).
- `HCLK` in 1: single clock.
- `HRESET` in 1: asynchronous, active-high reset.
- `HBUSREQ` in N_MASTERS: per-master bus request.
- `HTRANS_M` in 2*N_MASTERS: per-master HTRANS, master i at bits [2i+1:2i].
- `HADDR_M` in ADDR_WIDTH*N_MASTERS: per-master address.
- `HWRITE_M` in N_MASTERS: per-master write flag.
- `HWDATA_M` in DATA_WIDTH*N_MASTERS: per-master write data.
- `HREADY` in 1: bridge HREADY_OUT, also broadcast to masters externally.
- `HGRANT` out N_MASTERS: one-hot grant.
- `HMASTER` out $clog2(N_MASTERS): address-phase owner.
- `HSEL` out 1: bridge select, equal to muxed `HTRANS[1]`.
- `HTRANS` out 2: muxed HTRANS of `HMASTER`.
- `HADDR` out ADDR_WIDTH: muxed address of `HMASTER`.
- `HWRITE` out 1: muxed write flag of `HMASTER`.
- `HREADY_IN` out 1: equal to `HREADY`.
- `HWDATA` out DATA_WIDTH: write data of the data-phase owner.

## Operation
- Registers: `grant_idx` (drives one-hot `HGRANT`), `HMASTER`, `dp_owner` (data-phase owner), `hold_cnt` (4 bits).
- Reset values:
  - `HGRANT` = one-hot bit 0.
  - `HMASTER` = 0, `dp_owner` = 0, `hold_cnt` = 0.
  - `HTRANS`/`HSEL`/`HADDR`/`HWRITE` reflect master 0 inputs combinationally.
  - `HWDATA` = `HWDATA_M` of master 0.
- Accepted transfer: posedge with `HREADY`=1 and muxed `HTRANS[1]`=1.
- Re-arbitration condition, evaluated at posedges with `HREADY`=1 only:
  - (a) `HBUSREQ[grant_idx]`=0, or
  - (b) an accepted transfer occurs this edge, `hold_cnt`=MAX_HOLD-1, and any other master requests.
- Winner is the first requesting master scanning `grant_idx+1`, `grant_idx+2`, … modulo N_MASTERS, wrapping around.
  - The current owner is considered last, so under condition (a) with no other request the grant is unchanged.
  - With no requests at all, the grant parks on the current owner.
- `hold_cnt`:
  - Cleared when `grant_idx` changes.
  - Otherwise +1 on each accepted transfer, saturating at MAX_HOLD-1.
  - Unchanged on `HREADY`=0 edges.
- Handover, at a posedge with `HREADY`=1:
  - `HMASTER` <= current `grant_idx`, the value before any same-edge grant update.
  - `dp_owner` <= `HMASTER`.
- `HREADY`=0 freezes `grant_idx`, `HMASTER`, `dp_owner` and `hold_cnt`.
- Masters: a non-owner drives IDLE; the owner may drive IDLE while keeping its request.
- Preempted masters reissue their truncated transfer after the next grant. The bridge supports single NONSEQ transfers, so no burst bookkeeping is needed.

## Timing
- Grant latency: a request sampled at edge k with `HREADY`=1 and the condition met gives `HGRANT` at k.
  - The master's first address phase is owned (`HMASTER`) from edge k+1 when `HREADY`=1 at k+1.
  - An idle parked grant to the requester itself costs 0 extra cycles.
- Address path: muxes are combinational from `HMASTER`, zero latency.
- `HWDATA` follows `dp_owner`, one `HREADY`-qualified cycle behind `HMASTER`. Write data stays correct through bridge wait states.
- Simultaneous events:
  - Owner drops its request at the same edge its cap expires: treated as (a), same rotation.
  - Requests from all masters at once: the lowest index after the owner wins.
- `HRESET` asserted mid-transfer forces all registers to reset values immediately (asynchronous). The aborted transfer is not replayed.

## Test plan
- Reset:
  - Assert `HRESET` with all requests high → `HGRANT`=01, `HMASTER`=0, `HSEL` tracks master 0 `HTRANS[1]`.
  - Release → master 0 keeps the grant.
- Single requester:
  - Master 1 requests, master 0 idle → `HGRANT`=10 at the next edge, `HMASTER`=1 one edge later.
  - Write 0x0000_0004 ← 0xBEEF_BEEF lands in `apb_mem`; a read returns 0xBEEF_BEEF.
- Contention with MAX_HOLD=2:
  - Both masters issue continuous writes → ownership alternates every 2 accepted transfers (0,0,1,1,0,…).
  - All 8 writes (0x20..0x3C) read back correctly.
- Wait states:
  - The bridge holds `HREADY` low during APB access → `HMASTER`/`dp_owner` frozen.
  - `HWDATA` shows the data-phase owner's value (0xAAAA_0001, not master 1's 0xBBBB_0002) until `HREADY` rises.
- Parking:
  - All requests drop → grant stays on the last owner.
  - That owner later writes 0x50 ← 0xCAFE_BEEF with no handover delay; the readback matches.
- Reset mid-transfer:
  - Assert `HRESET` while master 1 owns the bus during a write data phase → outputs return to reset values within the same cycle.
  - After release, a master 0 read of 0x04 still completes normally.

Source files
------------

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter sharing one bridge slave port between N_MASTERS masters.
// Grants hand over AHB2-style and write data follows the data-phase owner.
module ahb_rr_arbiter #(
   parameter int N_MASTERS  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_HOLD   = 4
) (
   input  logic                            HCLK,
   input  logic                            HRESET,
   input  logic [N_MASTERS-1:0]            HBUSREQ,
   input  logic [2*N_MASTERS-1:0]          HTRANS_M,
   input  logic [ADDR_WIDTH*N_MASTERS-1:0] HADDR_M,
   input  logic [N_MASTERS-1:0]            HWRITE_M,
   input  logic [DATA_WIDTH*N_MASTERS-1:0] HWDATA_M,
   input  logic                            HREADY,
   output logic [N_MASTERS-1:0]            HGRANT,
   output logic [$clog2(N_MASTERS)-1:0]    HMASTER,
   output logic                            HSEL,
   output logic [1:0]                      HTRANS,
   output logic [ADDR_WIDTH-1:0]           HADDR,
   output logic                            HWRITE,
   output logic                            HREADY_IN,
   output logic [DATA_WIDTH-1:0]           HWDATA
);

   localparam int IW = $clog2(N_MASTERS);
   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   logic [IW-1:0] grant_idx;
   logic [IW-1:0] dp_owner;
   logic [IW-1:0] winner;
   logic [IW-1:0] next_grant;
   logic [3:0]    hold_cnt;
   logic          found;
   logic          accepted;
   logic          others_req;
   logic          rearb;

   // Address/control follow the address-phase owner, write data the data-phase owner.
   always_comb begin
      HTRANS = HTRANS_M[1:0];
      HADDR  = HADDR_M[ADDR_WIDTH-1:0];
      HWRITE = HWRITE_M[0];
      HWDATA = HWDATA_M[DATA_WIDTH-1:0];
      for (int i = 0; i < N_MASTERS; i++) begin
         if (HMASTER == IW'(i)) begin
            HTRANS = HTRANS_M[2*i +: 2];
            HADDR  = HADDR_M[ADDR_WIDTH*i +: ADDR_WIDTH];
            HWRITE = HWRITE_M[i];
         end
         if (dp_owner == IW'(i)) begin
            HWDATA = HWDATA_M[DATA_WIDTH*i +: DATA_WIDTH];
         end
      end
   end

   assign HSEL      = HTRANS[1];
   assign HREADY_IN = HREADY;

   always_comb begin
      HGRANT            = '0;
      HGRANT[grant_idx] = 1'b1;
   end

   // Scan starting after the owner; the owner itself is tried last, so it parks.
   always_comb begin
      winner = grant_idx;
      found  = 1'b0;
      for (int k = 1; k <= N_MASTERS; k++) begin
         for (int j = 0; j < N_MASTERS; j++) begin
            if (!found && j == (int'(grant_idx) + k) % N_MASTERS && HBUSREQ[j]) begin
               winner = IW'(j);
               found  = 1'b1;
            end
         end
      end
   end

   assign accepted   = HREADY & HTRANS[1];
   assign others_req = |(HBUSREQ & ~HGRANT);
   assign rearb      = !HBUSREQ[grant_idx] ||
                       (accepted && hold_cnt == HOLD_LAST && others_req);
   assign next_grant = rearb ? winner : grant_idx;

   // All ownership state only advances on HREADY edges, so wait states freeze it.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         grant_idx <= '0;
         HMASTER   <= '0;
         dp_owner  <= '0;
         hold_cnt  <= '0;
      end else if (HREADY) begin
         grant_idx <= next_grant;
         HMASTER   <= grant_idx;
         dp_owner  <= HMASTER;
         if (next_grant != grant_idx) begin
            hold_cnt <= '0;
         end else if (accepted && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Testbench for ahb_rr_arbiter: directed vector table, reset corner cases and a
// randomized run compared against a rule-level ownership model.
module tb_ahb_rr_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MH = 2;
   localparam int IW = $clog2(N);

   logic              HCLK = 1'b0;
   logic              HRESET;
   logic [N-1:0]      HBUSREQ;
   logic [2*N-1:0]    HTRANS_M;
   logic [AW*N-1:0]   HADDR_M;
   logic [N-1:0]      HWRITE_M;
   logic [DW*N-1:0]   HWDATA_M;
   logic              HREADY;
   logic [N-1:0]      HGRANT;
   logic [IW-1:0]     HMASTER;
   logic              HSEL;
   logic [1:0]        HTRANS;
   logic [AW-1:0]     HADDR;
   logic              HWRITE;
   logic              HREADY_IN;
   logic [DW-1:0]     HWDATA;

   int checks = 0;
   int errors = 0;

   ahb_rr_arbiter #(
      .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HTRANS_M(HTRANS_M),
      .HADDR_M(HADDR_M), .HWRITE_M(HWRITE_M), .HWDATA_M(HWDATA_M),
      .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER), .HSEL(HSEL),
      .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HREADY_IN(HREADY_IN),
      .HWDATA(HWDATA)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #2000000;
      $display("[TB] FAIL timeout actual=running expected=finished");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   typedef struct {
      logic [2:0] req;
      logic [2:0] nonseq;
      logic       rdy;
      logic [2:0] grant;
      int         hm;
      int         dp;
   } vec_t;

   vec_t vecs[18];
   logic [31:0] addr_tab[3];
   logic [31:0] data_tab[3];

   // Rule-level model of ownership
   int m_grant, m_hm, m_dp, m_cnt;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] req, input logic [2:0] nonseq, input logic rdy);
      HBUSREQ = req;
      for (int i = 0; i < N; i++) HTRANS_M[2*i +: 2] = nonseq[i] ? 2'b10 : 2'b00;
      HREADY = rdy;
   endtask

   task automatic applyRandom();
      HBUSREQ  = N'($urandom);
      HTRANS_M = (2*N)'($urandom);
      HWRITE_M = N'($urandom);
      for (int i = 0; i < N; i++) begin
         HADDR_M[AW*i +: AW]  = $urandom;
         HWDATA_M[DW*i +: DW] = $urandom;
      end
      HREADY = ($urandom_range(3) != 0);
   endtask

   task automatic modelStep();
      bit acc, others, cond;
      int ng;
      if (!HREADY) return;
      acc    = HTRANS_M[2*m_hm + 1];
      others = 1'b0;
      for (int j = 0; j < N; j++) if (j != m_grant && HBUSREQ[j]) others = 1'b1;
      cond = !HBUSREQ[m_grant] || (acc && m_cnt == MH - 1 && others);
      ng   = m_grant;
      if (cond) begin
         for (int d = 1; d <= N; d++) begin
            if (HBUSREQ[(m_grant + d) % N]) begin
               ng = (m_grant + d) % N;
               break;
            end
         end
      end
      if (ng != m_grant) m_cnt = 0;
      else if (acc && m_cnt < MH - 1) m_cnt = m_cnt + 1;
      m_dp    = m_hm;
      m_hm    = m_grant;
      m_grant = ng;
   endtask

   task automatic checkModel();
      checkOutput("rnd_hgrant", 64'(HGRANT), 64'(1 << m_grant));
      checkOutput("rnd_hmaster", 64'(HMASTER), 64'(m_hm));
      checkOutput("rnd_htrans", 64'(HTRANS), 64'(HTRANS_M[2*m_hm +: 2]));
      checkOutput("rnd_hsel", 64'(HSEL), 64'(HTRANS_M[2*m_hm + 1]));
      checkOutput("rnd_haddr", 64'(HADDR), 64'(HADDR_M[AW*m_hm +: AW]));
      checkOutput("rnd_hwrite", 64'(HWRITE), 64'(HWRITE_M[m_hm]));
      checkOutput("rnd_hwdata", 64'(HWDATA), 64'(HWDATA_M[DW*m_dp +: DW]));
      checkOutput("rnd_hready_in", 64'(HREADY_IN), 64'(HREADY));
   endtask

   initial begin
      addr_tab = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
      data_tab = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
      //            req     nonseq  rdy   grant   hm dp
      vecs[0]  = '{3'b001, 3'b001, 1'b1, 3'b001, 0, 0};
      vecs[1]  = '{3'b010, 3'b000, 1'b1, 3'b010, 0, 0};
      vecs[2]  = '{3'b010, 3'b010, 1'b1, 3'b010, 1, 0};
      vecs[3]  = '{3'b011, 3'b011, 1'b1, 3'b010, 1, 1};
      vecs[4]  = '{3'b011, 3'b011, 1'b1, 3'b001, 1, 1};
      vecs[5]  = '{3'b011, 3'b011, 1'b0, 3'b001, 1, 1};
      vecs[6]  = '{3'b011, 3'b011, 1'b1, 3'b001, 0, 1};
      vecs[7]  = '{3'b011, 3'b011, 1'b1, 3'b010, 0, 0};
      vecs[8]  = '{3'b011, 3'b011, 1'b0, 3'b010, 0, 0};
      vecs[9]  = '{3'b011, 3'b011, 1'b0, 3'b010, 0, 0};
      vecs[10] = '{3'b011, 3'b011, 1'b1, 3'b010, 1, 0};
      vecs[11] = '{3'b000, 3'b000, 1'b1, 3'b010, 1, 1};
      vecs[12] = '{3'b010, 3'b010, 1'b1, 3'b010, 1, 1};
      vecs[13] = '{3'b100, 3'b000, 1'b1, 3'b100, 1, 1};
      vecs[14] = '{3'b111, 3'b100, 1'b1, 3'b100, 2, 1};
      vecs[15] = '{3'b111, 3'b100, 1'b1, 3'b100, 2, 2};
      vecs[16] = '{3'b111, 3'b100, 1'b1, 3'b001, 2, 2};
      vecs[17] = '{3'b110, 3'b100, 1'b1, 3'b010, 0, 2};

      HWRITE_M = 3'b111;
      for (int i = 0; i < N; i++) begin
         HADDR_M[AW*i +: AW]  = addr_tab[i];
         HWDATA_M[DW*i +: DW] = data_tab[i];
      end

      // Reset with every master requesting
      HRESET = 1'b1;
      applyStimulus(3'b111, 3'b111, 1'b1);
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      checkOutput("reset_hgrant", 64'(HGRANT), 64'h1);
      checkOutput("reset_hmaster", 64'(HMASTER), 64'h0);
      checkOutput("reset_hsel_busy", 64'(HSEL), 64'h1);
      checkOutput("reset_hwdata", 64'(HWDATA), 64'hAAAA_0001);
      HTRANS_M[1:0] = 2'b00;
      #1;
      checkOutput("reset_hsel_idle", 64'(HSEL), 64'h0);
      @(negedge HCLK);
      HRESET = 1'b0;

      // Directed table
      for (int r = 0; r < 18; r++) begin
         applyStimulus(vecs[r].req, vecs[r].nonseq, vecs[r].rdy);
         @(posedge HCLK);
         #1;
         checkOutput($sformatf("vec%0d_hgrant", r), 64'(HGRANT), 64'(vecs[r].grant));
         checkOutput($sformatf("vec%0d_hmaster", r), 64'(HMASTER), 64'(vecs[r].hm));
         checkOutput($sformatf("vec%0d_hwdata", r), 64'(HWDATA), 64'(data_tab[vecs[r].dp]));
         checkOutput($sformatf("vec%0d_haddr", r), 64'(HADDR), 64'(addr_tab[vecs[r].hm]));
         checkOutput($sformatf("vec%0d_hsel", r), 64'(HSEL), 64'(vecs[r].nonseq[vecs[r].hm]));
      end

      // Reset while master 1 owns a write data phase
      applyStimulus(3'b010, 3'b010, 1'b1);
      repeat (2) @(posedge HCLK);
      #1;
      checkOutput("pre_rst_hmaster", 64'(HMASTER), 64'h1);
      checkOutput("pre_rst_hwdata", 64'(HWDATA), 64'hBBBB_0002);
      #2;
      HRESET = 1'b1;
      #1;
      checkOutput("mid_rst_hgrant", 64'(HGRANT), 64'h1);
      checkOutput("mid_rst_hmaster", 64'(HMASTER), 64'h0);
      checkOutput("mid_rst_hwdata", 64'(HWDATA), 64'hAAAA_0001);
      checkOutput("mid_rst_haddr", 64'(HADDR), 64'h1000);
      @(negedge HCLK);
      HRESET = 1'b0;
      HWRITE_M = 3'b000;
      applyStimulus(3'b001, 3'b001, 1'b1);
      repeat (2) @(posedge HCLK);
      #1;
      checkOutput("post_rst_hgrant", 64'(HGRANT), 64'h1);
      checkOutput("post_rst_hmaster", 64'(HMASTER), 64'h0);
      checkOutput("post_rst_hsel", 64'(HSEL), 64'h1);
      checkOutput("post_rst_hwrite", 64'(HWRITE), 64'h0);

      // Randomized run against the model
      @(negedge HCLK);
      HRESET = 1'b1;
      m_grant = 0; m_hm = 0; m_dp = 0; m_cnt = 0;
      @(negedge HCLK);
      HRESET = 1'b0;
      for (int c = 0; c < 600; c++) begin
         applyRandom();
         #1;
         checkModel();
         modelStep();
         @(posedge HCLK);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
